nios_cpu_trace_capture_buffer: RTL and testbench
================================================

// Module: nios_cpu_trace_capture_buffer
// PURPOSE
//  On-chip instruction-trace capture buffer for the Nios II debug core. Runs in the CPU clock domain
//  and sits directly upstream of the JTAG debug module: it captures trace words into a circular RAM and
//  drives trc_on/trc_wrap/trc_im_addr/tracemem_* back to it for shift-out. It consumes the
//  sysclk-side jdo bus and the take_action_tracectrl / take_action_tracemem_* strobes as its control path.
// PARAMETERS
//  ADDR_W   7   trace RAM address width; depth = 2**ADDR_W words
//  DATA_W   36  trace word width; matches tracemem_trcdata
//  JDO_W    38  width of the jdo control bus
// PORTS
//  clk                        in   1       CPU clock; only clock in the block
//  reset                      in   1       synchronous, active-high reset
//  jdo                        in   JDO_W   JTAG data-out word, valid while any take_* strobe is high
//  take_action_tracectrl      in   1       1-cycle strobe: load trace control from jdo
//  take_action_tracemem_a     in   1       1-cycle strobe: load read address from jdo, then read
//  take_no_action_tracemem_a  in   1       1-cycle strobe: re-read at current read address
//  take_action_tracemem_b     in   1       1-cycle strobe: advance read address, then read
//  trace_valid                in   1       CPU trace word valid this cycle
//  trace_data                 in   DATA_W  CPU trace word
//  trace_stop                 in   1       break/trigger request to stop capture
//  trc_on                     out  1       capture enabled
//  trc_wrap                   out  1       write pointer has wrapped at least once since clear
//  trc_im_addr                out  ADDR_W  next write address (also the oldest entry once wrapped)
//  tracemem_on                out  1       trace memory enabled for readout (= trc_on)
//  tracemem_trcdata           out  DATA_W  registered read data
//  tracemem_tw                out  1       read word belongs to the previous lap (stale-order flag)
// BEHAVIOUR
//  - Reset: trc_on=0, trc_wrap=0, trc_im_addr=0, rd_addr=0, tracemem_trcdata=0, tracemem_tw=0. RAM is not cleared.
//  - Control: on take_action_tracectrl, trc_on <= jdo[CTL_EN]. If jdo[CTL_CLR]=1, also trc_im_addr<=0, trc_wrap<=0.
//  - Capture: when trc_on & trace_valid, write mem[trc_im_addr] <= trace_data; trc_im_addr <= +1 mod 2**ADDR_W.
//    On 2**ADDR_W-1 -> 0, trc_wrap <= 1 (sticky until a clear).
//  - trace_stop: trc_on <= 0 on the next edge. A capture in the same cycle is still written.
//  - Priority, same cycle: reset > tracectrl clear (suppresses that cycle's write; the pointer lands on 0) >
//    trace_stop over CTL_EN=1 (trc_on ends 0) > capture.
//  - Read address:
//      take_action_tracemem_a: rd_addr <= jdo[RD_LSB +: ADDR_W].
//      take_action_tracemem_b: rd_addr <= rd_addr+1 mod depth.
//      take_no_action_tracemem_a: rd_addr holds.
//    Each of these strobes starts one read of the new rd_addr. tracemem_trcdata updates 2 cycles after the
//    strobe (1 cycle address register + 1 cycle RAM read register) and holds until the next read.
//  - Strobe precedence, same cycle: tracemem_a > tracemem_b > no_action.
//  - RAM is read-first. A read and a capture to the same address in the same cycle returns the old word.
//  - tracemem_tw is registered with the data: 1 iff trc_wrap=1 and rd_addr >= trc_im_addr at RAM-read time.
//  - Reads are legal while trc_on=1; there is no stall and no backpressure. trace_valid is never dropped
//    while trc_on=1.
//  - No FSM beyond the trc_on flag. Pointers wrap silently; overflow overwrites the oldest entry by design.
// STRUCTURE
//  - Shared package nios_cpu_trace_pkg:
//      localparams CTL_EN=4, CTL_CLR=3, RD_LSB=19 (jdo field positions);
//      typedef trace_word_t = logic[DATA_W-1:0].
//  - One sub-module nios_cpu_trace_ram: simple dual-port, 1 write / 1 registered read, read-first,
//    2**ADDR_W x DATA_W. Inferable as M9K/M10K.
//  - Top level holds the pointers, trc_wrap, trc_on, rd_addr, the strobe decode and tracemem_tw.
// TESTING
//  1. Reset with trace_valid=1 held -> trc_on=0, trc_im_addr=0, no writes; tracemem_a to addr 0 reads the
//     preloaded RAM pattern unchanged.
//  2. tracectrl jdo[4]=1, jdo[3]=1; 5 valid words 0xA0..0xA4 -> trc_im_addr=5, trc_wrap=0;
//     tracemem_a rd=2 -> trcdata=0xA2, tw=0, 2 cycles after the strobe.
//  3. 130 valid words from count 0 -> trc_im_addr=2, trc_wrap=1; rd=2 -> word 2 (oldest), tw=1;
//     tracemem_b -> word 3; rd=1 -> word 129, tw=0.
//  4. Same cycle: trace_stop=1 and tracectrl EN=1 -> trc_on=0; same-cycle valid word is written.
//  5. Same cycle: tracectrl CLR=1 and trace_valid=1 -> trc_im_addr=0, trc_wrap=0, RAM[old ptr] unchanged.
//  6. Read rd=7 while capturing into addr 7 in the same cycle -> old word returned; re-read next cycle -> new word.

Source files
------------

// File: rtl/nios_cpu_trace_pkg.sv
// Shared definitions for the Nios II trace capture buffer: jdo field positions and the trace word type.
package nios_cpu_trace_pkg;

  localparam int CTL_EN       = 4;
  localparam int CTL_CLR      = 3;
  localparam int RD_LSB       = 19;
  localparam int TRACE_DATA_W = 36;

  typedef logic [TRACE_DATA_W-1:0] trace_word_t;

  typedef struct packed {
    logic en;
    logic clr;
  } trace_ctl_t;

endpackage

// File: rtl/nios_cpu_trace_capture_buffer_if.sv
// Bundle between the trace buffer and its JTAG debug / CPU neighbours.
interface nios_cpu_trace_capture_buffer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 36,
  parameter int JDO_W  = 38
);

  logic [JDO_W-1:0]  jdo;
  logic              take_action_tracectrl;
  logic              take_action_tracemem_a;
  logic              take_no_action_tracemem_a;
  logic              take_action_tracemem_b;
  logic              trace_valid;
  logic [DATA_W-1:0] trace_data;
  logic              trace_stop;

  logic              trc_on;
  logic              trc_wrap;
  logic [ADDR_W-1:0] trc_im_addr;
  logic              tracemem_on;
  logic [DATA_W-1:0] tracemem_trcdata;
  logic              tracemem_tw;

  modport slave (
    input  jdo, take_action_tracectrl, take_action_tracemem_a,
           take_no_action_tracemem_a, take_action_tracemem_b,
           trace_valid, trace_data, trace_stop,
    output trc_on, trc_wrap, trc_im_addr, tracemem_on, tracemem_trcdata, tracemem_tw
  );

  modport master (
    output jdo, take_action_tracectrl, take_action_tracemem_a,
           take_no_action_tracemem_a, take_action_tracemem_b,
           trace_valid, trace_data, trace_stop,
    input  trc_on, trc_wrap, trc_im_addr, tracemem_on, tracemem_trcdata, tracemem_tw
  );

endinterface

// File: rtl/nios_cpu_trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read-first read port.
module nios_cpu_trace_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata_p2
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata_p2;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register: holds its word between reads; same-address write is seen only on the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_p2 <= '0;
    end else if (i_re) begin
      r_rdata_p2 <= r_mem[i_raddr];
    end
  end

  assign o_rdata_p2 = r_rdata_p2;

endmodule

// File: rtl/nios_cpu_trace_capture_buffer.sv
// Nios II instruction-trace capture buffer: circular capture RAM, control decode and JTAG readout path.
module nios_cpu_trace_capture_buffer
  import nios_cpu_trace_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 36,
  parameter int JDO_W  = 38
) (
  input logic clk,
  input logic reset,
  nios_cpu_trace_capture_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return p + 1'b1;
  endfunction

  logic              r_trc_on;
  logic              r_trc_wrap;
  logic [ADDR_W-1:0] r_im_addr;
  logic [ADDR_W-1:0] r_rd_addr_p1;
  logic              r_rd_vld_p1;
  logic              r_tw_p2;

  trace_ctl_t        w_ctl;
  logic              w_ctl_clr;
  logic              w_wr_en;
  logic              w_rd_strobe;
  logic [DATA_W-1:0] w_rdata_p2;
  logic              w_unused_jdo;

  assign w_ctl.en     = bus.jdo[CTL_EN];
  assign w_ctl.clr    = bus.jdo[CTL_CLR];
  assign w_unused_jdo = ^bus.jdo;

  // A clear in the same cycle as a capture wins: the pointer lands on 0 and nothing is written.
  assign w_ctl_clr   = bus.take_action_tracectrl & w_ctl.clr;
  assign w_wr_en     = r_trc_on & bus.trace_valid & ~w_ctl_clr;
  assign w_rd_strobe = bus.take_action_tracemem_a | bus.take_action_tracemem_b |
                       bus.take_no_action_tracemem_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trc_on     <= 1'b0;
      r_trc_wrap   <= 1'b0;
      r_im_addr    <= '0;
      r_rd_addr_p1 <= '0;
      r_rd_vld_p1  <= 1'b0;
      r_tw_p2      <= 1'b0;
    end else begin
      if (bus.trace_stop) begin
        r_trc_on <= 1'b0;
      end else if (bus.take_action_tracectrl) begin
        r_trc_on <= w_ctl.en;
      end

      if (w_ctl_clr) begin
        r_im_addr  <= '0;
        r_trc_wrap <= 1'b0;
      end else if (w_wr_en) begin
        r_im_addr <= ptr_inc(r_im_addr);
        if (r_im_addr == LAST_ADDR) r_trc_wrap <= 1'b1;
      end

      // Stage p0 -> p1: strobe decode into the read address register.
      if (bus.take_action_tracemem_a) begin
        r_rd_addr_p1 <= bus.jdo[RD_LSB +: ADDR_W];
      end else if (bus.take_action_tracemem_b) begin
        r_rd_addr_p1 <= ptr_inc(r_rd_addr_p1);
      end
      r_rd_vld_p1 <= w_rd_strobe;

      // Stage p1 -> p2: stale-lap flag is captured alongside the RAM read data.
      if (r_rd_vld_p1) begin
        r_tw_p2 <= r_trc_wrap & (r_rd_addr_p1 >= r_im_addr);
      end
    end
  end

  nios_cpu_trace_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk        (clk),
    .rst        (reset),
    .i_we       (w_wr_en),
    .i_waddr    (r_im_addr),
    .i_wdata    (bus.trace_data),
    .i_re       (r_rd_vld_p1),
    .i_raddr    (r_rd_addr_p1),
    .o_rdata_p2 (w_rdata_p2)
  );

  assign bus.trc_on           = r_trc_on;
  assign bus.trc_wrap         = r_trc_wrap;
  assign bus.trc_im_addr      = r_im_addr;
  assign bus.tracemem_on      = r_trc_on;
  assign bus.tracemem_trcdata = w_rdata_p2;
  assign bus.tracemem_tw      = r_tw_p2;

endmodule

// File: tb/tb_nios_cpu_trace_capture_buffer.sv
// Directed bench for the trace capture buffer: capture, wrap, stop/clear priority and read-first readout.
module tb_nios_cpu_trace_capture_buffer;
  import nios_cpu_trace_pkg::*;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 36;
  localparam int JDO_W  = 38;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  nios_cpu_trace_capture_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .JDO_W(JDO_W)) bus ();

  nios_cpu_trace_capture_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .JDO_W(JDO_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [JDO_W-1:0] jdo_ctl(input logic en, input logic clr);
    logic [JDO_W-1:0] j;
    j = '0;
    j[CTL_EN]  = en;
    j[CTL_CLR] = clr;
    return j;
  endfunction

  function automatic logic [JDO_W-1:0] jdo_rd(input logic [ADDR_W-1:0] a);
    logic [JDO_W-1:0] j;
    j = '0;
    j[RD_LSB +: ADDR_W] = a;
    return j;
  endfunction

  task automatic ctl_pulse(input logic en, input logic clr);
    bus.jdo = jdo_ctl(en, clr);
    bus.take_action_tracectrl = 1'b1;
    tick();
    bus.take_action_tracectrl = 1'b0;
    bus.jdo = '0;
  endtask

  task automatic rd_a(input logic [ADDR_W-1:0] a);
    bus.jdo = jdo_rd(a);
    bus.take_action_tracemem_a = 1'b1;
    tick();
    bus.take_action_tracemem_a = 1'b0;
    bus.jdo = '0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    bus.jdo = '0;
    bus.take_action_tracectrl = 1'b0;
    bus.take_action_tracemem_a = 1'b0;
    bus.take_no_action_tracemem_a = 1'b0;
    bus.take_action_tracemem_b = 1'b0;
    bus.trace_valid = 1'b1;
    bus.trace_data = 36'hFF;
    bus.trace_stop = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) dut.u_ram.r_mem[i] = 36'hB_0000_0000 | 36'(i);

    // 1: reset with trace_valid held high
    tick(); tick(); tick();
    chk("rst_trc_on", 64'(bus.trc_on), 64'h0);
    chk("rst_wrap", 64'(bus.trc_wrap), 64'h0);
    chk("rst_im_addr", 64'(bus.trc_im_addr), 64'h0);
    chk("rst_trcdata", 64'(bus.tracemem_trcdata), 64'h0);
    chk("rst_tw", 64'(bus.tracemem_tw), 64'h0);
    chk("rst_mem_on", 64'(bus.tracemem_on), 64'h0);
    reset = 1'b0;
    tick(); tick();
    chk("off_no_capture", 64'(bus.trc_im_addr), 64'h0);
    bus.trace_valid = 1'b0;
    rd_a(7'd0);
    chk("preload_addr0", 64'(bus.tracemem_trcdata), 64'hB_0000_0000);

    // 2: enable+clear, 5 words, read back with latency check
    ctl_pulse(1'b1, 1'b1);
    chk("en_trc_on", 64'(bus.trc_on), 64'h1);
    chk("en_mem_on", 64'(bus.tracemem_on), 64'h1);
    for (int k = 0; k < 5; k++) begin
      bus.trace_valid = 1'b1;
      bus.trace_data = 36'hA0 + 36'(k);
      tick();
    end
    bus.trace_valid = 1'b0;
    chk("t2_im_addr", 64'(bus.trc_im_addr), 64'h5);
    chk("t2_wrap", 64'(bus.trc_wrap), 64'h0);
    bus.jdo = jdo_rd(7'd2);
    bus.take_action_tracemem_a = 1'b1;
    tick();
    bus.take_action_tracemem_a = 1'b0;
    bus.jdo = '0;
    chk("t2_lat1_hold", 64'(bus.tracemem_trcdata), 64'hB_0000_0000);
    tick();
    chk("t2_rd2", 64'(bus.tracemem_trcdata), 64'hA2);
    chk("t2_tw", 64'(bus.tracemem_tw), 64'h0);

    // 3: 130 words from a cleared pointer -> wrapped
    ctl_pulse(1'b1, 1'b1);
    for (int k = 0; k < 130; k++) begin
      bus.trace_valid = 1'b1;
      bus.trace_data = 36'(k);
      tick();
    end
    bus.trace_valid = 1'b0;
    chk("t3_im_addr", 64'(bus.trc_im_addr), 64'h2);
    chk("t3_wrap", 64'(bus.trc_wrap), 64'h1);
    rd_a(7'd2);
    chk("t3_oldest", 64'(bus.tracemem_trcdata), 64'h2);
    chk("t3_oldest_tw", 64'(bus.tracemem_tw), 64'h1);
    bus.take_action_tracemem_b = 1'b1;
    tick();
    bus.take_action_tracemem_b = 1'b0;
    tick();
    chk("t3_b_next", 64'(bus.tracemem_trcdata), 64'h3);
    chk("t3_b_tw", 64'(bus.tracemem_tw), 64'h1);
    rd_a(7'd1);
    chk("t3_newest", 64'(bus.tracemem_trcdata), 64'd129);
    chk("t3_newest_tw", 64'(bus.tracemem_tw), 64'h0);

    // 4: trace_stop beats tracectrl EN=1; same-cycle word is still captured
    bus.trace_stop = 1'b1;
    bus.trace_valid = 1'b1;
    bus.trace_data = 36'h5A5A;
    bus.jdo = jdo_ctl(1'b1, 1'b0);
    bus.take_action_tracectrl = 1'b1;
    tick();
    bus.trace_stop = 1'b0;
    bus.take_action_tracectrl = 1'b0;
    bus.jdo = '0;
    chk("t4_trc_on", 64'(bus.trc_on), 64'h0);
    chk("t4_mem_on", 64'(bus.tracemem_on), 64'h0);
    chk("t4_im_addr", 64'(bus.trc_im_addr), 64'h3);
    tick();
    chk("t4_stopped", 64'(bus.trc_im_addr), 64'h3);
    bus.trace_valid = 1'b0;
    rd_a(7'd2);
    chk("t4_last_word", 64'(bus.tracemem_trcdata), 64'h5A5A);
    chk("t4_tw", 64'(bus.tracemem_tw), 64'h0);

    // 5: clear with a same-cycle valid word suppresses the write
    ctl_pulse(1'b1, 1'b0);
    bus.trace_valid = 1'b1;
    bus.trace_data = 36'hDEAD;
    bus.jdo = jdo_ctl(1'b1, 1'b1);
    bus.take_action_tracectrl = 1'b1;
    tick();
    bus.take_action_tracectrl = 1'b0;
    bus.trace_valid = 1'b0;
    bus.jdo = '0;
    chk("t5_im_addr", 64'(bus.trc_im_addr), 64'h0);
    chk("t5_wrap", 64'(bus.trc_wrap), 64'h0);
    chk("t5_trc_on", 64'(bus.trc_on), 64'h1);
    rd_a(7'd3);
    chk("t5_old_ptr_kept", 64'(bus.tracemem_trcdata), 64'h3);

    // 6: read-first collision at address 7
    for (int k = 0; k < 7; k++) begin
      bus.trace_valid = 1'b1;
      bus.trace_data = 36'h70 + 36'(k);
      tick();
    end
    bus.trace_valid = 1'b0;
    chk("t6_im_addr", 64'(bus.trc_im_addr), 64'h7);
    bus.jdo = jdo_rd(7'd7);
    bus.take_action_tracemem_a = 1'b1;
    tick();
    bus.take_action_tracemem_a = 1'b0;
    bus.jdo = '0;
    bus.trace_valid = 1'b1;
    bus.trace_data = 36'h777;
    tick();
    bus.trace_valid = 1'b0;
    chk("t6_read_first", 64'(bus.tracemem_trcdata), 64'h7);
    bus.take_no_action_tracemem_a = 1'b1;
    tick();
    bus.take_no_action_tracemem_a = 1'b0;
    tick();
    chk("t6_reread_new", 64'(bus.tracemem_trcdata), 64'h777);

    // strobe precedence: tracemem_a wins over tracemem_b
    bus.jdo = jdo_rd(7'd5);
    bus.take_action_tracemem_a = 1'b1;
    bus.take_action_tracemem_b = 1'b1;
    tick();
    bus.take_action_tracemem_a = 1'b0;
    bus.take_action_tracemem_b = 1'b0;
    bus.jdo = '0;
    tick();
    chk("prec_a_over_b", 64'(bus.tracemem_trcdata), 64'h75);
    bus.take_action_tracemem_b = 1'b1;
    tick();
    bus.take_action_tracemem_b = 1'b0;
    tick();
    chk("b_after_a", 64'(bus.tracemem_trcdata), 64'h76);
    tick(); tick();
    chk("data_holds", 64'(bus.tracemem_trcdata), 64'h76);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
